sdf_r2_butterfly: RTL and testbench

- Radix-2 single-path delay-feedback (SDF) butterfly stage for the 64-point pipelined FFT. Sits directly upstream of the twiddle multiplier stage.
- Accepts one complex sample per enabled cycle, in natural order.
- Emits butterfly sums and differences with one bit of growth.
- Also emits the in-frame position counter that drives the multiplier's cnt_mult select.

---
 rtl/sdf_r2_butterfly.sv | 97 +++++++++
 tb/tb_sdf_r2_butterfly.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdf_r2_butterfly.sv
// rtl/sdf_r2_butterfly.sv - radix-2 single-path delay-feedback butterfly stage with output frame position
module sdf_r2_butterfly #(
    parameter int WIDTH      = 14,
    parameter int LOG2_DEPTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sync_clr,
    input  logic                  in_valid,
    input  logic [WIDTH-1:0]      in_re,
    input  logic [WIDTH-1:0]      in_im,
    output logic                  out_valid,
    output logic [WIDTH:0]        out_re,
    output logic [WIDTH:0]        out_im,
    output logic [LOG2_DEPTH:0]   cnt_out,
    output logic                  frame_start
);

    localparam int DEPTH = 2 ** LOG2_DEPTH;
    localparam int XW    = WIDTH + 1;

    logic [LOG2_DEPTH:0]   pos;
    logic [LOG2_DEPTH-1:0] ptr;
    logic                  primed;

    // Feedback line holds {re, im}; contents are meaningless until primed.
    logic [2*XW-1:0] delay_mem [DEPTH];

    logic [XW-1:0]       x_re, x_im, h_re, h_im;
    logic [XW-1:0]       cand_re, cand_im, wr_re, wr_im;
    logic                phase_b, accept, emit;
    logic [LOG2_DEPTH:0] cnt_next;

    assign x_re   = {in_re[WIDTH-1], in_re};
    assign x_im   = {in_im[WIDTH-1], in_im};
    assign {h_re, h_im} = delay_mem[ptr];
    assign accept = in_valid & ~sync_clr;

    always_comb begin
        phase_b  = pos[LOG2_DEPTH];
        cand_re  = h_re;
        cand_im  = h_im;
        wr_re    = x_re;
        wr_im    = x_im;
        if (phase_b) begin
            cand_re = h_re + x_re;
            cand_im = h_im + x_im;
            wr_re   = h_re - x_re;
            wr_im   = h_im - x_im;
        end
        emit     = primed | phase_b;
        // Output frame is offset by DEPTH from the input frame: flip the phase bit.
        cnt_next = {~pos[LOG2_DEPTH], pos[LOG2_DEPTH-1:0]};
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            delay_mem[ptr] <= {wr_re, wr_im};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos         <= '0;
            ptr         <= '0;
            primed      <= 1'b0;
            out_valid   <= 1'b0;
            out_re      <= '0;
            out_im      <= '0;
            cnt_out     <= '0;
            frame_start <= 1'b0;
        end else if (sync_clr) begin
            pos         <= '0;
            ptr         <= '0;
            primed      <= 1'b0;
            out_valid   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            out_valid   <= accept & emit;
            frame_start <= accept & emit & (cnt_next == '0);
            if (accept) begin
                pos <= pos + 1'b1;
                ptr <= ptr + 1'b1;
                if (phase_b) begin
                    primed <= 1'b1;
                end
                // Suppressed first-frame garbage never disturbs the held output.
                if (emit) begin
                    out_re  <= cand_re;
                    out_im  <= cand_im;
                    cnt_out <= cnt_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_sdf_r2_butterfly.sv
// tb/tb_sdf_r2_butterfly.sv - directed self-checking bench for sdf_r2_butterfly
module tb_sdf_r2_butterfly;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sync_clr;
    logic        in_valid;
    logic [13:0] in_re, in_im;
    logic        out_valid;
    logic [14:0] out_re, out_im;
    logic [5:0]  cnt_out;
    logic        frame_start;

    int vectors = 0;
    int miscompares = 0;

    logic        capture = 1'b0;
    logic [14:0] cap_re[$];
    logic [14:0] cap_im[$];
    logic [5:0]  cap_cnt[$];

    sdf_r2_butterfly #(.WIDTH(14), .LOG2_DEPTH(5)) dut (
        .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr), .in_valid(in_valid),
        .in_re(in_re), .in_im(in_im), .out_valid(out_valid), .out_re(out_re),
        .out_im(out_im), .cnt_out(cnt_out), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (capture && out_valid) begin
            cap_re.push_back(out_re);
            cap_im.push_back(out_im);
            cap_cnt.push_back(cnt_out);
        end
    end

    task automatic drive(input logic v, input int re, input int im, input logic clr);
        in_valid = v;
        in_re    = re[13:0];
        in_im    = im[13:0];
        sync_clr = clr;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sync_clr = 1'b0;
    endtask

    task automatic restart();
        drive(1'b0, 0, 0, 1'b1);
    endtask

    task automatic test_reset();
        logic [37:0] got;
        rst_n = 1'b0; sync_clr = 1'b0; in_valid = 1'b0; in_re = '0; in_im = '0;
        repeat (2) @(posedge clk);
        #1;
        got = {out_valid, out_re, out_im, cnt_out, frame_start};
        if (got !== 38'h0) begin
            miscompares++;
            $display("FAIL reset_state got %h want %h", got, 38'h0);
        end
        vectors++;
        rst_n = 1'b1;
    endtask

    task automatic test_constant();
        logic [37:0] got, exp;
        int er, c;
        restart();
        for (int n = 0; n < 128; n++) begin
            drive(1'b1, 100, 0, 1'b0);
            if (n < 32) begin
                if (out_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL const_quiet n=%0d got out_valid=%b want 0", n, out_valid);
                end
            end else begin
                er  = (n < 64 || n >= 96) ? 200 : 0;
                c   = (n < 96) ? n - 32 : n - 96;
                exp = {1'b1, 15'(er), 15'(0), 6'(c), 1'(c == 0)};
                got = {out_valid, out_re, out_im, cnt_out, frame_start};
                if (got !== exp) begin
                    miscompares++;
                    $display("FAIL const n=%0d got %h want %h", n, got, exp);
                end
            end
            vectors++;
        end
    endtask

    task automatic test_impulse();
        logic [37:0] got, exp;
        int er, ei, c;
        restart();
        for (int n = 0; n < 128; n++) begin
            drive(1'b1, (n == 0) ? 1000 : 0, (n == 0) ? -500 : 0, 1'b0);
            if (n >= 32) begin
                er  = (n == 32 || n == 64) ? 1000 : 0;
                ei  = (n == 32 || n == 64) ? -500 : 0;
                c   = (n < 96) ? n - 32 : n - 96;
                exp = {1'b1, 15'(er), 15'(ei), 6'(c), 1'(c == 0)};
                got = {out_valid, out_re, out_im, cnt_out, frame_start};
                if (got !== exp) begin
                    miscompares++;
                    $display("FAIL impulse n=%0d got %h want %h", n, got, exp);
                end
                vectors++;
            end
        end
    endtask

    task automatic test_extremes(input int a, input int b, input int sum, input int diff);
        logic [37:0] got, exp;
        int x;
        restart();
        for (int n = 0; n < 96; n++) begin
            x = (n < 32 || n >= 64) ? a : b;
            drive(1'b1, x, x, 1'b0);
            if (n >= 32) begin
                x   = (n < 64) ? sum : diff;
                exp = {1'b1, 15'(x), 15'(x), 6'(n - 32), 1'(n == 32)};
                got = {out_valid, out_re, out_im, cnt_out, frame_start};
                if (got !== exp) begin
                    miscompares++;
                    $display("FAIL extremes a=%0d b=%0d n=%0d got %h want %h", a, b, n, got, exp);
                end
                vectors++;
            end
        end
    endtask

    task automatic test_gaps();
        logic [35:0] got, exp;
        int k, er, c;
        restart();
        cap_re.delete(); cap_im.delete(); cap_cnt.delete();
        capture = 1'b1;
        k = 0;
        while (k < 128) begin
            if (k == 32) begin
                repeat (3) drive(1'b0, 0, 0, 1'b0);
                if (out_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL stall_valid got %b want 0", out_valid);
                end
                vectors++;
            end else if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) drive(1'b0, 0, 0, 1'b0);
            end
            drive(1'b1, k, -k, 1'b0);
            k++;
        end
        drive(1'b0, 0, 0, 1'b0);
        capture = 1'b0;
        if (cap_re.size() != 96) begin
            miscompares++;
            $display("FAIL gaps_count got %0d want 96", cap_re.size());
        end
        vectors++;
        for (int i = 0; i < cap_re.size() && i < 96; i++) begin
            k  = i + 32;
            er = (k >= 64 && k < 96) ? -32 : 2 * k - 32;
            c  = (k < 96) ? k - 32 : k - 96;
            exp = {15'(er), 15'(-er), 6'(c)};
            got = {cap_re[i], cap_im[i], cap_cnt[i]};
            if (got !== exp) begin
                miscompares++;
                $display("FAIL gaps k=%0d got %h want %h", k, got, exp);
            end
            vectors++;
        end
    endtask

    task automatic test_async_reset();
        logic [37:0] got, exp;
        restart();
        for (int n = 0; n < 109; n++) begin
            drive(1'b1, (n % 64) + 1, 0, 1'b0);
        end
        rst_n = 1'b0;
        #2;
        got = {out_valid, out_re, out_im, cnt_out, frame_start};
        if (got !== 38'h0) begin
            miscompares++;
            $display("FAIL rst_async got %h want %h", got, 38'h0);
        end
        vectors++;
        @(posedge clk);
        #1;
        got = {out_valid, out_re, out_im, cnt_out, frame_start};
        if (got !== 38'h0) begin
            miscompares++;
            $display("FAIL rst_hold got %h want %h", got, 38'h0);
        end
        vectors++;
        rst_n = 1'b1;
        for (int n = 0; n < 33; n++) begin
            drive(1'b1, 7, 0, 1'b0);
            exp = (n < 32) ? 38'h0 : {1'b1, 15'd14, 15'd0, 6'd0, 1'b1};
            got = (n < 32) ? {out_valid, 37'h0} : {out_valid, out_re, out_im, cnt_out, frame_start};
            if (got !== exp) begin
                miscompares++;
                $display("FAIL rst_restart n=%0d got %h want %h", n, got, exp);
            end
            vectors++;
        end
    endtask

    task automatic test_sync_clr();
        logic [37:0] got, exp;
        restart();
        for (int n = 0; n < 20; n++) begin
            drive(1'b1, 3, 0, 1'b0);
        end
        drive(1'b1, 999, 0, 1'b1);
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL clr_valid got %b want 0", out_valid);
        end
        vectors++;
        for (int n = 0; n < 40; n++) begin
            drive(1'b1, 9, 0, 1'b0);
            exp = (n < 32) ? 38'h0 : {1'b1, 15'd18, 15'd0, 6'(n - 32), 1'(n == 32)};
            got = (n < 32) ? {out_valid, 37'h0} : {out_valid, out_re, out_im, cnt_out, frame_start};
            if (got !== exp) begin
                miscompares++;
                $display("FAIL clr_restart n=%0d got %h want %h", n, got, exp);
            end
            vectors++;
        end
    endtask

    initial begin
        test_reset();
        test_constant();
        test_impulse();
        test_extremes(-8192, -8192, -16384, 0);
        test_extremes(8191, -8192, -1, 16383);
        test_gaps();
        test_async_reset();
        test_sync_clr();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
